// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, 16x oversampling FSM, optional even parity.
// Define UART_RX_PARITY_EN to compile in the PARITY state and the parity_err check.
module uart_rx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SB_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned SW = (SB_TICKS > 16) ? $clog2(SB_TICKS) : 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [SW-1:0]          s_q, s_d;
  logic [2:0]             n_q, n_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   done_q, done_d;
  logic                   frame_err_q, frame_err_d;
  // Set when a frame ends with the line low; blocks a new start until the line goes high.
  logic                   wait_high_q, wait_high_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
    wait_high_d = wait_high_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (wait_high_q) begin
          if (rx_s_q) wait_high_d = 1'b0;
        end else if (!rx_s_q) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (sample_tick) begin
          if (s_q == SW'(7)) begin
            if (!rx_s_q) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StData: begin
        if (sample_tick) begin
          if (s_q == SW'(15)) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            s_d     = '0;
            if (n_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (sample_tick) begin
          if (s_q == SW'(15)) begin
            par_bit_d = rx_s_q;
            s_d       = '0;
            state_d   = StStop;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      StStop: begin
        if (sample_tick) begin
          if (s_q == SW'(SB_TICKS - 1)) begin
            rx_data_d   = shift_q;
            frame_err_d = ~rx_s_q;
            done_d      = 1'b1;
            wait_high_d = ~rx_s_q;
            state_d     = StIdle;
`ifdef UART_RX_PARITY_EN
            parity_err_d = (^shift_q) ^ par_bit_q;
`endif
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      s_q         <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wait_high_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      s_q         <= s_d;
      n_q         <= n_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      wait_high_q <= wait_high_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_done_tick = done_q;
  assign frame_err    = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = parity_err_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule
